// File: rtl/seq_array_div_pkg.sv
// Shared definitions for the sequential restoring divider: default widths
// and the controller state encoding.
package seq_array_div_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_VW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_array_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it is non-negative.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   rem_i,
  input  logic          bit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   rem_o,
  output logic          qbit_o
);

  logic [VW+1:0] shifted;
  logic [VW+1:0] trial;

  // One spare bit above the shifted value lets the sign of the trial show up.
  assign shifted = {rem_i, bit_i};
  assign trial   = shifted - {2'b00, divisor_i};
  assign qbit_o  = ~trial[VW+1];
  assign rem_o   = qbit_o ? trial[VW:0] : shifted[VW:0];

endmodule

// File: rtl/seq_array_div.sv
// Sequential unsigned divider: one quotient bit per clock, MSB first, with a
// divide-by-zero shortcut straight to DONE.
module seq_array_div
  import seq_array_div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW:0]   prem_q, prem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   step_rem;
  logic          step_qbit;

  div_step #(.VW(VW)) u_step (
    .rem_i     (prem_q),
    .bit_i     (dvd_q[DW-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            prem_d  = '0;
            cnt_d   = CNT_LAST;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        // Dividend bits leave at the top while quotient bits enter at the bottom.
        prem_d = step_rem;
        dvd_d  = {dvd_q[DW-2:0], step_qbit};
        if (cnt_q == '0) begin
          quo_d   = {dvd_q[DW-2:0], step_qbit};
          rem_d   = step_rem[VW-1:0];
          dbz_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_CALC) || (state_q == ST_DONE);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_array_div.sv
// Directed and randomized checks of seq_array_div against an arithmetic
// reference (integer / and %), including latency, hold-off and reset cases.
module tb_seq_array_div;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int n_cmp = 0;
  int n_mis = 0;

  seq_array_div #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one request and waits for done. With hold set, start stays high
  // with scrambled operands throughout, and is left high on return.
  task automatic run_div(input int a, input int b, input bit hold, input string tag);
    int exp_q, exp_r, exp_z, exp_lat, edges;
    if (b == 0) begin
      exp_q = (1 << DW) - 1; exp_r = 0; exp_z = 1; exp_lat = 2;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_z = 0; exp_lat = DW + 2;
    end
    @(negedge clk);
    dividend = DW'(a);
    divisor  = VW'(b);
    start    = 1'b1;
    edges    = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) check({tag, " busy"}, 32'(busy), 32'd1);
      if (!hold) start = 1'b0;
      dividend = DW'($urandom);
      divisor  = VW'($urandom_range(1, (1 << VW) - 1));
    end while (!done && edges < DW + 6);
    check({tag, " latency"}, 32'(edges + 1), 32'(exp_lat));
    check({tag, " quotient"}, 32'(quotient), 32'(exp_q));
    check({tag, " remainder"}, 32'(remainder), 32'(exp_r));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(exp_z));
    if (!hold) begin
      @(negedge clk);
      check({tag, " done_pulse"}, 32'(done), 32'd0);
      check({tag, " idle_busy"}, 32'(busy), 32'd0);
      check({tag, " held_q"}, 32'(quotient), 32'(exp_q));
    end
  endtask

  initial begin
    int n_done;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #3;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst quotient", 32'(quotient), 32'd0);
    check("rst remainder", 32'(remainder), 32'd0);
    check("rst dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_div(200, 7, 1'b0, "200/7");
    run_div(255, 15, 1'b0, "255/15");
    run_div(255, 1, 1'b0, "255/1");
    run_div(7, 15, 1'b0, "7/15");
    run_div(0, 9, 1'b0, "0/9");
    run_div(200, 0, 1'b0, "200/0");
    run_div(9, 3, 1'b0, "9/3");

    // start held through CALC, then a second start right on the IDLE cycle
    run_div(173, 6, 1'b1, "hold first");
    run_div(77, 5, 1'b0, "back2back");

    // reset asserted between clock edges part-way through CALC
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst quotient", 32'(quotient), 32'd0);
    check("midrst remainder", 32'(remainder), 32'd0);
    check("midrst dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    n_done = 0;
    repeat (DW + 4) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst no_done", 32'(n_done), 32'd0);
    run_div(100, 9, 1'b0, "100/9");

    for (int i = 0; i < 24; i++) begin
      int a, b;
      a = int'($urandom_range(0, (1 << DW) - 1));
      b = int'($urandom_range(0, (1 << VW) - 1));
      run_div(a, b, (i % 4 == 3), $sformatf("rand%0d", i));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (DW + 4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
